// File: rtl/mult_div_unit.sv
// Multicycle signed multiply/divide coprocessor: radix-2 Booth multiply and
// restoring magnitude divide with MIPS sign rules, results in HI/LO.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MULT_control,
  input  logic                  DIV_control,
  input  logic [DATA_WIDTH-1:0] A_in,
  input  logic [DATA_WIDTH-1:0] B_in,
  output logic [DATA_WIDTH-1:0] HI_out,
  output logic [DATA_WIDTH-1:0] LO_out,
  output logic                  multStop,
  output logic                  divStop,
  output logic                  divZero
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] MULT_RUN = 3'd1;
  localparam logic [2:0] DIV_RUN  = 3'd2;
  localparam logic [2:0] DIV_FIX  = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  logic [2:0]       state;
  logic [CNT_W-1:0] count;
  logic             mult_q;
  logic             div_q;

  // Booth datapath: accumulator carries one guard bit so that subtracting
  // the most negative multiplicand cannot overflow.
  logic [W:0]       acc;
  logic [W-1:0]     q;
  logic             q_m1;
  logic [W-1:0]     mcand;

  // Divide datapath, operating on magnitudes.
  logic [W-1:0]     rem;
  logic [W-1:0]     quo;
  logic [W-1:0]     dvsr;
  logic             neg_q;
  logic             neg_r;

  logic             start_m;
  logic             start_d;
  logic             b_zero;
  logic [W-1:0]     abs_a;
  logic [W-1:0]     abs_b;

  logic [W:0]       mcand_ext;
  logic [W:0]       booth_sum;
  logic [W:0]       acc_step;
  logic [W-1:0]     q_step;

  logic [W:0]       shifted;
  logic             fits;
  logic [W-1:0]     rem_step;
  logic [W-1:0]     quo_step;

  always_comb begin
    start_m = MULT_control & ~mult_q;
    start_d = DIV_control & ~div_q;
    b_zero  = (B_in == '0);
    abs_a   = A_in[W-1] ? -A_in : A_in;
    abs_b   = B_in[W-1] ? -B_in : B_in;
  end

  always_comb begin
    mcand_ext = {mcand[W-1], mcand};
    booth_sum = acc;
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + mcand_ext;
      2'b10:   booth_sum = acc - mcand_ext;
      default: booth_sum = acc;
    endcase
    acc_step = {booth_sum[W], booth_sum[W:1]};
    q_step   = {booth_sum[0], q[W-1:1]};
  end

  // Remainder stays below the divisor, so the subtracted value fits in W bits.
  always_comb begin
    shifted  = {rem, quo[W-1]};
    fits     = (shifted >= {1'b0, dvsr});
    rem_step = fits ? (shifted[W-1:0] - dvsr) : shifted[W-1:0];
    quo_step = {quo[W-2:0], fits};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      count    <= '0;
      mult_q   <= 1'b0;
      div_q    <= 1'b0;
      acc      <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      mcand    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      HI_out   <= '0;
      LO_out   <= '0;
      multStop <= 1'b0;
      divStop  <= 1'b0;
      divZero  <= 1'b0;
    end else begin
      // Edge samplers run every cycle so requests outside IDLE are consumed.
      mult_q <= MULT_control;
      div_q  <= DIV_control;
      case (state)
        IDLE: begin
          if (start_m) begin
            mcand <= A_in;
            q     <= B_in;
            acc   <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            state <= MULT_RUN;
          end else if (start_d) begin
            if (b_zero) begin
              divStop <= 1'b1;
              divZero <= 1'b1;
              state   <= DONE;
            end else begin
              rem   <= '0;
              quo   <= abs_a;
              dvsr  <= abs_b;
              neg_q <= A_in[W-1] ^ B_in[W-1];
              neg_r <= A_in[W-1];
              count <= '0;
              state <= DIV_RUN;
            end
          end
        end
        MULT_RUN: begin
          if (count == LAST_STEP) begin
            HI_out   <= acc[W-1:0];
            LO_out   <= q;
            multStop <= 1'b1;
            state    <= DONE;
          end else begin
            acc   <= acc_step;
            q     <= q_step;
            q_m1  <= q[0];
            count <= count + 1'b1;
          end
        end
        DIV_RUN: begin
          if (count == LAST_STEP) begin
            quo   <= neg_q ? -quo : quo;
            rem   <= neg_r ? -rem : rem;
            state <= DIV_FIX;
          end else begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + 1'b1;
          end
        end
        DIV_FIX: begin
          HI_out  <= rem;
          LO_out  <= quo;
          divStop <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          multStop <= 1'b0;
          divStop  <= 1'b0;
          divZero  <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: scoreboard of reference results, one task per scenario.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        MULT_control;
  logic        DIV_control;
  logic [31:0] A_in;
  logic [31:0] B_in;
  logic [31:0] HI_out;
  logic [31:0] LO_out;
  logic        multStop;
  logic        divStop;
  logic        divZero;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        zero;
    int          lat;
  } exp_t;

  exp_t sb[$];
  logic [31:0] last_hi = 32'h0;
  logic [31:0] last_lo = 32'h0;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .MULT_control(MULT_control), .DIV_control(DIV_control),
    .A_in(A_in), .B_in(B_in),
    .HI_out(HI_out), .LO_out(LO_out),
    .multStop(multStop), .divStop(divStop), .divZero(divZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_mult(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    e.hi = p[63:32]; e.lo = p[31:0]; e.zero = 1'b0; e.lat = 33;
    last_hi = e.hi; last_lo = e.lo;
    sb.push_back(e);
  endtask

  task automatic push_div(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint la, lb, qq, rr;
    if (b == 32'h0) begin
      e.hi = last_hi; e.lo = last_lo; e.zero = 1'b1; e.lat = 0;
    end else begin
      la = longint'($signed(a));
      lb = longint'($signed(b));
      qq = la / lb;
      rr = la % lb;
      e.hi = rr[31:0]; e.lo = qq[31:0]; e.zero = 1'b0; e.lat = 34;
      last_hi = e.hi; last_lo = e.lo;
    end
    sb.push_back(e);
  endtask

  // Raises the request(s), scrambles operands after E0, and reports what the DUT did.
  task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] hi, output logic [31:0] lo,
                       output logic zero, output int other, output int early, output int after);
    logic [31:0] prev_hi, prev_lo;
    @(negedge clk);
    A_in = a; B_in = b; MULT_control = m; DIV_control = d;
    lat = -1; other = 0; early = 0; after = 0;
    hi = 'x; lo = 'x; zero = 1'bx;
    prev_hi = HI_out; prev_lo = LO_out;
    @(posedge clk);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (k == 0) begin A_in = $urandom; B_in = $urandom; end
      if (m ? divStop : multStop) other++;
      if (m ? multStop : divStop) begin
        lat = k; hi = HI_out; lo = LO_out; zero = divZero;
        break;
      end
      if (HI_out !== prev_hi || LO_out !== prev_lo) early++;
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (multStop | divStop | divZero) after++;
    end
    MULT_control = 1'b0; DIV_control = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; MULT_control = 1'b0; DIV_control = 1'b0; A_in = '0; B_in = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({HI_out, LO_out} !== 64'h0) begin
      tests_failed++; $display("FAIL reset_hilo: got %h_%h want 0_0", HI_out, LO_out);
    end
    tests_run++;
    if ({multStop, divStop, divZero} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags: got %b want 000", {multStop, divStop, divZero});
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ops(input string name, input logic is_div,
                          input logic [31:0] av[], input logic [31:0] bv[]);
    int lat, other, early, after;
    logic [31:0] hi, lo;
    logic zero;
    exp_t e;
    for (int i = 0; i < av.size(); i++) begin
      if (is_div) push_div(av[i], bv[i]); else push_mult(av[i], bv[i]);
      do_op(!is_div, is_div, av[i], bv[i], lat, hi, lo, zero, other, early, after);
      e = sb.pop_front();
      $display("[TB] %s a=%h b=%h -> hi=%h lo=%h zero=%b lat=%0d", name, av[i], bv[i], hi, lo, zero, lat);
      tests_run++;
      if (lat !== e.lat) begin tests_failed++; $display("FAIL %s_latency: got %0d want %0d", name, lat, e.lat); end
      tests_run++;
      if (hi !== e.hi) begin tests_failed++; $display("FAIL %s_hi: got %h want %h", name, hi, e.hi); end
      tests_run++;
      if (lo !== e.lo) begin tests_failed++; $display("FAIL %s_lo: got %h want %h", name, lo, e.lo); end
      tests_run++;
      if (zero !== e.zero) begin tests_failed++; $display("FAIL %s_divzero: got %b want %b", name, zero, e.zero); end
      tests_run++;
      if (other !== 0 || early !== 0 || after !== 0) begin
        tests_failed++;
        $display("FAIL %s_pulses: wrong_stop=%0d early_hilo=%0d extra_pulse=%0d want 0/0/0", name, other, early, after);
      end
    end
  endtask

  task automatic test_hold_level();
    int pulses = 0;
    logic [31:0] hi = 'x, lo = 'x;
    exp_t e;
    push_mult(32'h0001_2345, 32'hFFFF_0F00);
    @(negedge clk);
    A_in = 32'h0001_2345; B_in = 32'hFFFF_0F00; MULT_control = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (multStop) begin pulses++; hi = HI_out; lo = LO_out; end
    end
    MULT_control = 1'b0;
    e = sb.pop_front();
    $display("[TB] hold_level pulses=%0d hi=%h lo=%h", pulses, hi, lo);
    tests_run++;
    if (pulses !== 1) begin tests_failed++; $display("FAIL hold_pulses: got %0d want 1", pulses); end
    tests_run++;
    if ({hi, lo} !== {e.hi, e.lo}) begin
      tests_failed++; $display("FAIL hold_result: got %h_%h want %h_%h", hi, lo, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_simultaneous();
    int lat, other, early, after;
    logic [31:0] hi, lo;
    logic zero;
    exp_t e;
    push_mult(32'h0000_0101, 32'hFFFF_FFF0);
    do_op(1'b1, 1'b1, 32'h0000_0101, 32'hFFFF_FFF0, lat, hi, lo, zero, other, early, after);
    e = sb.pop_front();
    $display("[TB] simultaneous hi=%h lo=%h lat=%0d divstops=%0d", hi, lo, lat, other);
    tests_run++;
    if (lat !== e.lat || {hi, lo} !== {e.hi, e.lo}) begin
      tests_failed++; $display("FAIL simul_mult: got lat=%0d %h_%h want lat=%0d %h_%h", lat, hi, lo, e.lat, e.hi, e.lo);
    end
    tests_run++;
    if (other !== 0 || after !== 0) begin
      tests_failed++; $display("FAIL simul_nodiv: divStop=%0d extra=%0d want 0/0", other, after);
    end
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    int lat, other, early, after;
    logic [31:0] hi, lo;
    logic zero;
    exp_t e;
    @(negedge clk);
    A_in = 32'h0000_1234; B_in = 32'h0000_5678; MULT_control = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    $display("[TB] reset_abort hi=%h lo=%h flags=%b", HI_out, LO_out, {multStop, divStop, divZero});
    tests_run++;
    if ({HI_out, LO_out} !== 64'h0) begin
      tests_failed++; $display("FAIL abort_hilo: got %h_%h want 0_0", HI_out, LO_out);
    end
    last_hi = 32'h0; last_lo = 32'h0;
    @(negedge clk);
    MULT_control = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (multStop | divStop) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin tests_failed++; $display("FAIL abort_nostop: got %0d pulses want 0", pulses); end
    push_mult(32'd3, 32'd4);
    do_op(1'b1, 1'b0, 32'd3, 32'd4, lat, hi, lo, zero, other, early, after);
    e = sb.pop_front();
    $display("[TB] after_reset mult hi=%h lo=%h lat=%0d", hi, lo, lat);
    tests_run++;
    if (lat !== e.lat || {hi, lo} !== {e.hi, e.lo} || after !== 0) begin
      tests_failed++;
      $display("FAIL post_reset_mult: got lat=%0d %h_%h extra=%0d want lat=%0d %h_%h", lat, hi, lo, after, e.lat, e.hi, e.lo);
    end
  endtask

  initial begin
    logic [31:0] ma[], mb[], da[], db[];
    ma = '{32'd7, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0, 32'hDEAD_BEEF};
    mb = '{32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_1234, 32'h0BAD_F00D};
    da = '{32'hFFFF_FFF9, 32'd7, 32'h0000_0692, 32'd5, 32'h8000_0000, 32'hFFFF_FF9C, 32'h0000_0003};
    db = '{32'd2, 32'hFFFF_FFFE, 32'h0000_0020, 32'h0, 32'hFFFF_FFFF, 32'd7, 32'h7FFF_FFFF};
    test_reset();
    test_ops("mult", 1'b0, ma, mb);
    test_ops("div", 1'b1, da, db);
    test_hold_level();
    test_simultaneous();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
